// File: rtl/load_store_unit.sv
// Load/store initiator between the execute stage and data memory.
// It handles one request at a time: address, strobe, then a fixed-latency wait and a one-cycle response.
module load_store_unit #(
    parameter int unsigned MEM_LATENCY = 1,  // 0..15; 0 means a combinational read
    parameter int unsigned CNT_W       = 4   // 2**CNT_W must exceed MEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE, so the datapath holds the request until then.
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [31:0] base_addr,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_data,
    output logic [7:0]  err_count,
    output logic [31:0] mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_data_in,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_is_store;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_resp_data;
    logic [7:0]       r_err_count;
    logic [31:0]      r_mem_address;
    logic [31:0]      r_mem_write_data;

    logic [31:0]      w_ea;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_capture;
    logic             w_zero_latency;

    // Carry out of the add is dropped, so base+offset wraps modulo 2^32.
    assign w_ea           = base_addr + offset;
    assign w_misaligned   = (w_ea[1:0] != 2'b00);
    assign w_zero_latency = (MEM_LATENCY == 0);
    assign w_accept       = (r_state == S_IDLE) && req_valid;

    // Read data is sampled at the end of ACCESS for a zero-latency memory,
    // otherwise at the end of the last WAIT cycle.
    assign w_capture = !r_is_store &&
                       (((r_state == S_ACCESS) && w_zero_latency) ||
                        ((r_state == S_WAIT) && (r_cnt == CNT_W'(1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        req_ready        = 1'b0;
        stall            = 1'b1;
        resp_valid       = 1'b0;
        resp_error       = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
                if (req_valid) begin
                    w_next = w_misaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_write_enable = r_is_store;
                mem_read_enable  = !r_is_store;
                if (r_is_store || w_zero_latency) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_read_enable = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_error = r_err;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_store       <= 1'b0;
            r_err            <= 1'b0;
            r_err_count      <= 8'd0;
            r_mem_address    <= 32'd0;
            r_mem_write_data <= 32'd0;
        end else if (w_accept) begin
            r_err <= w_misaligned;
            if (w_misaligned) begin
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else begin
                r_mem_address    <= w_ea;
                r_mem_write_data <= store_data;
                r_is_store       <= req_is_store;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= CNT_W'(MEM_LATENCY);
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Only successful loads update the returned word; stores and errors leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_data <= 32'd0;
        end else if (w_capture) begin
            r_resp_data <= mem_data_in;
        end
    end

    assign resp_data      = r_resp_data;
    assign err_count      = r_err_count;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign o_dbg_state    = r_state;

    a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(mem_read_enable && mem_write_enable));
    a_resp_one_cycle: assert property (@(posedge clk) disable iff (rst)
        resp_valid |=> !resp_valid);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a randomized scoreboard on a MEM_LATENCY=1 instance,
// plus directed runs on MEM_LATENCY=0 and MEM_LATENCY=3 instances.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int unsigned L_MAIN = 1;
  localparam int EW = 81;  // {err, data[31:0], err_count[7:0], latency[7:0], accept_cycle[31:0]}
  localparam int AW = 65;  // {is_store, address[31:0], write_data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none (t=%0t)", name, $time);
  endtask

  // ---------------- main DUT (MEM_LATENCY=1) ----------------
  logic        rst;
  logic        req_valid;
  logic        req_is_store;
  logic [31:0] base_addr;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_data;
  logic [7:0]  err_count;
  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_data_in;
  logic [1:0]  dbg_state;

  load_store_unit #(.MEM_LATENCY(L_MAIN), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_store(req_is_store),
    .base_addr(base_addr), .offset(offset), .store_data(store_data),
    .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_data(resp_data),
    .err_count(err_count),
    .mem_address(mem_address), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_data_in(mem_data_in), .o_dbg_state(dbg_state)
  );

  // Data memory seen by the main DUT; unread cycles return noise.
  logic [31:0] dmem [logic [31:0]];
  always @(negedge clk) begin
    if (mem_write_enable) dmem[mem_address] = mem_write_data;
    if (mem_read_enable) mem_data_in = dmem.exists(mem_address) ? dmem[mem_address] : 32'h0;
    else mem_data_in = $urandom;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_last = 32'h0;
  int          ref_err_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] acc_q[$];

  task automatic issue(input logic st, input logic [31:0] b, input logic [31:0] o,
                       input logic [31:0] d, output int unsigned acc);
    logic [31:0] ea;
    logic        err;
    logic [7:0]  lat;
    bit          ok;
    req_is_store = st; base_addr = b; offset = o; store_data = d; req_valid = 1'b1;
    ok = 0;
    acc = 0;
    for (int i = 0; i < 64; i++) begin
      check("stall_vs_ready", 32'(stall), req_ready ? 32'd0 : 32'd1);
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      fail_event("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    ea = b + o;
    if (ea[1:0] != 2'b00) begin
      err = 1'b1;
      if (ref_err_cnt < 255) ref_err_cnt++;
      lat = 8'd1;
    end else if (st) begin
      err = 1'b0;
      ref_mem[ea] = d;
      lat = 8'd2;
      acc_q.push_back({1'b1, ea, d});
    end else begin
      err = 1'b0;
      ref_last = ref_mem.exists(ea) ? ref_mem[ea] : 32'h0;
      lat = 8'(2 + L_MAIN);
      acc_q.push_back({1'b0, ea, 32'h0});
    end
    exp_q.push_back({err, ref_last, 8'(ref_err_cnt), lat, acc});
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_is_store = 1'($urandom_range(0, 1));
    base_addr = $urandom; offset = $urandom; store_data = $urandom;
    repeat (n) @(negedge clk);
  endtask

  // Response monitor
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          fail_event("unexpected_resp");
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_error", 32'(resp_error), 32'(mon_e[80]));
          check("resp_data", resp_data, mon_e[79:48]);
          check("err_count", 32'(err_count), 32'(mon_e[47:40]));
          check("latency", cyc - mon_e[31:0] + 1, 32'(mon_e[39:32]));
        end
      end else if (resp_error) begin
        fail_event("resp_error_without_valid");
      end
    end
  end

  // Memory-strobe monitor
  logic          acc_on = 1'b0;
  int            acc_dur = 0;
  logic [AW-1:0] acc_e = '0;
  always @(negedge clk) begin
    if (rst) begin
      acc_on = 1'b0;
    end else begin
      if (mem_read_enable && mem_write_enable) fail_event("strobe_overlap");
      if (mem_read_enable || mem_write_enable) begin
        if (!acc_on) begin
          acc_on = 1'b1;
          acc_dur = 1;
          if (acc_q.size() == 0) begin
            fail_event("unexpected_strobe");
            acc_e = '0;
          end else begin
            acc_e = acc_q.pop_front();
            check("strobe_kind", 32'(mem_write_enable), 32'(acc_e[64]));
            check("mem_address", mem_address, acc_e[63:32]);
            if (acc_e[64]) check("mem_write_data", mem_write_data, acc_e[31:0]);
          end
        end else begin
          acc_dur++;
          check("addr_stable", mem_address, acc_e[63:32]);
        end
      end else if (acc_on) begin
        acc_on = 1'b0;
        check("strobe_cycles", 32'(acc_dur), acc_e[64] ? 32'd1 : 32'(1 + L_MAIN));
      end
    end
  end

  task automatic main_seq();
    int unsigned a1;
    int unsigned a2;
    logic [31:0] pool [8];
    logic [31:0] ea;
    logic [31:0] b;
    bit          drained;
    pool = '{32'h0000_0100, 32'h0000_0104, 32'hFFFF_FFFC, 32'h0000_0000,
             32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFC, 32'h0000_0FF0};
    @(negedge clk);
    // store then load, same word
    issue(1'b1, 32'h100, 32'h4, 32'hDEAD_BEEF, a1);
    issue(1'b0, 32'h100, 32'h4, 32'h0, a1);
    idle(2);
    // negative offset wrapping past zero
    issue(1'b1, 32'h0000_0004, 32'hFFFF_FFF8, 32'h0BAD_F00D, a1);
    issue(1'b0, 32'h0000_0004, 32'hFFFF_FFF8, 32'h0, a1);
    // misaligned
    issue(1'b0, 32'h100, 32'h2, 32'h0, a1);
    issue(1'b1, 32'h100, 32'h3, 32'h1111_1111, a1);
    // back-to-back loads with req_valid held high
    issue(1'b0, 32'h100, 32'h4, 32'h0, a1);
    issue(1'b0, 32'h0, 32'h104, 32'h0, a2);
    check("b2b_spacing", a2 - a1, 32'(2 + L_MAIN + 1));
    // randomized mix
    for (int i = 0; i < 150; i++) begin
      ea = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) ea = ea + 32'($urandom_range(1, 3));
      b = $urandom;
      issue(1'($urandom_range(0, 1)), b, ea - b, $urandom, a1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    // saturate the misaligned counter
    for (int i = 0; i < 300; i++) begin
      ea = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      b = $urandom;
      issue(1'($urandom_range(0, 1)), b, ea - b, $urandom, a1);
    end
    idle(1);
    drained = 0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !stall) begin drained = 1; break; end
      @(negedge clk);
    end
    if (!drained) fail_event("drain_timeout");
    check("err_count_saturated", 32'(err_count), 32'd255);
    check("acc_queue_empty", 32'(acc_q.size()), 32'd0);
  endtask

  // ---------------- extra instances: [0] MEM_LATENCY=0, [1] MEM_LATENCY=3 ----------------
  logic        x_rst [2];
  logic        x_valid [2];
  logic        x_store [2];
  logic [31:0] x_base [2];
  logic [31:0] x_off [2];
  logic [31:0] x_sd [2];
  logic [31:0] x_mdi [2];
  logic        x_ready [2];
  logic        x_stall [2];
  logic        x_rv [2];
  logic        x_re [2];
  logic [31:0] x_rdata [2];
  logic [7:0]  x_ec [2];
  logic [31:0] x_addr [2];
  logic        x_rd [2];
  logic        x_wr [2];
  logic [31:0] x_wd [2];
  logic [1:0]  x_dbg [2];

  for (genvar k = 0; k < 2; k++) begin : g_x
    load_store_unit #(.MEM_LATENCY(k == 0 ? 0 : 3), .CNT_W(4)) u_x (
      .clk(clk), .rst(x_rst[k]),
      .req_valid(x_valid[k]), .req_is_store(x_store[k]),
      .base_addr(x_base[k]), .offset(x_off[k]), .store_data(x_sd[k]),
      .req_ready(x_ready[k]), .stall(x_stall[k]),
      .resp_valid(x_rv[k]), .resp_error(x_re[k]), .resp_data(x_rdata[k]),
      .err_count(x_ec[k]),
      .mem_address(x_addr[k]), .mem_read_enable(x_rd[k]),
      .mem_write_enable(x_wr[k]), .mem_write_data(x_wd[k]),
      .mem_data_in(x_mdi[k]), .o_dbg_state(x_dbg[k])
    );
  end

  // Address-derived read data: a load of A returns A ^ 0xCAFE0000.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) x_mdi[k] = x_rd[k] ? (x_addr[k] ^ 32'hCAFE_0000) : $urandom;
  end

  task automatic x_run(input int k, input logic st, input logic [31:0] b, input logic [31:0] o,
                       output int lat, output logic err, output logic [31:0] data);
    bit ok;
    bit got;
    x_store[k] = st; x_base[k] = b; x_off[k] = o; x_sd[k] = $urandom; x_valid[k] = 1'b1;
    lat = 0; err = 1'b0; data = 32'h0;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (x_ready[k]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      fail_event("x_accept_timeout");
      x_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 x_valid[k] = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      @(negedge clk);
      if (x_rv[k]) begin got = 1; break; end
      @(posedge clk);
    end
    if (!got) begin
      fail_event("x_resp_timeout");
      return;
    end
    err = x_re[k];
    data = x_rdata[k];
  endtask

  task automatic l0_seq();
    int          lat;
    logic        err;
    logic [31:0] d;
    x_run(0, 1'b0, 32'h40, 32'h8, lat, err, d);
    check("l0_load_latency", 32'(lat), 32'd2);
    check("l0_load_data", d, 32'hCAFE_0048);
    check("l0_load_err", 32'(err), 32'd0);
    x_run(0, 1'b1, 32'h40, 32'h0, lat, err, d);
    check("l0_store_latency", 32'(lat), 32'd2);
    check("l0_store_keeps_data", d, 32'hCAFE_0048);
    x_run(0, 1'b0, 32'h41, 32'h0, lat, err, d);
    check("l0_misaligned_latency", 32'(lat), 32'd1);
    check("l0_misaligned_err", 32'(err), 32'd1);
    check("l0_err_count", 32'(x_ec[0]), 32'd1);
  endtask

  task automatic l3_seq();
    int          lat;
    logic        err;
    logic [31:0] d;
    int          n;
    bit          ok;
    x_store[1] = 1'b0; x_base[1] = 32'h80; x_off[1] = 32'h0; x_valid[1] = 1'b1;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (x_ready[1]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) fail_event("l3_accept_timeout");
    @(posedge clk);
    #1 x_valid[1] = 1'b0;
    @(negedge clk);
    check("l3_rd_in_access", 32'(x_rd[1]), 32'd1);
    @(negedge clk);
    check("l3_rd_in_wait", 32'(x_rd[1]), 32'd1);
    // Reset between edges: everything must drop without a clock.
    #2 x_rst[1] = 1'b1;
    #1;
    check("l3_rst_rd_drop", 32'(x_rd[1]), 32'd0);
    check("l3_rst_ready", 32'(x_ready[1]), 32'd1);
    check("l3_rst_stall", 32'(x_stall[1]), 32'd0);
    check("l3_rst_resp_valid", 32'(x_rv[1]), 32'd0);
    check("l3_rst_resp_data", x_rdata[1], 32'h0);
    @(negedge clk);
    x_rst[1] = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (x_rv[1]) n++;
    end
    check("l3_no_resp_after_abort", 32'(n), 32'd0);
    x_run(1, 1'b0, 32'h80, 32'h4, lat, err, d);
    check("l3_load_latency", 32'(lat), 32'd5);
    check("l3_load_data", d, 32'hCAFE_0084);
  endtask

  // ---------------- top sequence ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0;
    base_addr = 32'h0; offset = 32'h0; store_data = 32'h0;
    for (int k = 0; k < 2; k++) begin
      x_rst[k] = 1'b1; x_valid[k] = 1'b0; x_store[k] = 1'b0;
      x_base[k] = 32'h0; x_off[k] = 32'h0; x_sd[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_read_enable", 32'(mem_read_enable), 32'd0);
    check("rst_mem_write_enable", 32'(mem_write_enable), 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'h0);
    rst = 1'b0;
    x_rst[0] = 1'b0;
    x_rst[1] = 1'b0;
    fork
      main_seq();
      l0_seq();
      l3_seq();
    join
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the datapath.
- Computes the effective address and drives address/read-enable/write-enable/write-data into the data memory.
- Waits a fixed number of memory-latency cycles, then returns a one-cycle response with load data or an alignment error.
- Sits between the execute stage and data_memory; holds the pipeline via stall while busy.

Parameters:
- MEM_LATENCY, 1, cycles after the access cycle before read data is sampled; legal range 0..15 (0 = combinational read).
- CNT_W, 4, width of the internal latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present; sampled only while req_ready=1.
- req_is_store  input  1  1 = store, 0 = load.
- base_addr  input  32  base register value.
- offset  input  32  sign-extended immediate offset.
- store_data  input  32  data to write for stores.
- req_ready  output  1  high only in IDLE.
- stall  output  1  high whenever state != IDLE.
- resp_valid  output  1  one-cycle completion pulse.
- resp_error  output  1  qualifies resp_valid; 1 = misaligned, no memory access done.
- resp_data  output  32  last successfully loaded word.
- err_count  output  8  saturating count of misaligned requests.
- mem_address  output  32  word-aligned effective address to the memory.
- mem_read_enable  output  1  read strobe.
- mem_write_enable  output  1  write strobe.
- mem_write_data  output  32  write data to the memory.
- mem_data_in  input  32  read data from the memory.

Behaviour:
- Reset: asynchronous; state goes to IDLE immediately.
  - Reset values: req_ready=1, stall=0, resp_valid=0, resp_error=0, resp_data=0, err_count=0, mem_address=0, mem_read_enable=0, mem_write_enable=0, mem_write_data=0.
  - Reset mid-operation aborts the access: strobes drop asynchronously and no response is issued.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- Effective address: ea = base_addr + offset, modulo 2^32; carry is discarded, so wrap-around is legal.
- IDLE, edge with req_valid=1:
  - If ea[1:0] != 0: go to RESP with error flag set; err_count += 1, saturating at 255. No memory strobe is ever asserted.
  - Otherwise: register mem_address=ea, mem_write_data=store_data and the request type; go to ACCESS.
  - req_valid=0: stay in IDLE.
- ACCESS, one cycle:
  - Store: mem_write_enable=1 for exactly this cycle (the memory writes on the closing edge); next state RESP.
  - Load: mem_read_enable=1; counter loaded with MEM_LATENCY. If MEM_LATENCY=0, capture mem_data_in into resp_data at the closing edge and go to RESP. Otherwise go to WAIT.
- WAIT:
  - mem_read_enable stays 1; mem_address is held stable.
  - Counter decrements each cycle. On the edge where the counter equals 1, capture mem_data_in into resp_data and go to RESP.
- RESP, one cycle:
  - resp_valid=1; resp_error reflects the misaligned flag; strobes are 0. Next state IDLE.
  - A new request is accepted no earlier than the following IDLE cycle.
- resp_data updates only on successful loads; stores and errors leave it unchanged.
- resp_error=0 whenever resp_valid=0.
- mem_read_enable and mem_write_enable are never high simultaneously.
- Latency from the accepting edge to the resp_valid cycle:
  - load = 2 + MEM_LATENCY cycles.
  - store = 2 cycles.
  - misaligned = 1 cycle.
- Throughput: at most one request per (latency + 1) cycles.
- req_valid asserted while busy is ignored; the datapath must hold the request until it sees req_ready.

Test Plan:
- Aligned store, then load, MEM_LATENCY=1: store base=0x100, off=0x4, data=0xDEADBEEF -> mem_address=0x104 with write strobe for exactly 1 cycle, resp_valid 2 cycles after acceptance. Load of the same address -> read strobe for 2 cycles, resp_data=0xDEADBEEF, resp_valid 3 cycles after acceptance.
- Negative offset and wrap: base=0x00000004, off=0xFFFFFFF8 -> mem_address=0xFFFFFFFC, access proceeds with no error.
- Misaligned: base=0x100, off=0x2 -> resp_valid with resp_error=1 one cycle later, no strobe ever asserted, err_count increments. After 300 misaligned requests, err_count=255.
- Back-to-back: req_valid held high with two loads -> second accepted only in the IDLE cycle after RESP, and stall is high throughout the first access.
- Reset asserted in WAIT (MEM_LATENCY=3) -> mem_read_enable drops without a clock edge, no resp_valid, req_ready=1, and resp_data keeps 0 from reset.
- MEM_LATENCY=0 build: load -> data captured at the end of ACCESS, resp_valid 2 cycles after acceptance.
